// File: rtl/quad_encoder_gen.sv
// Quadrature transmitter: walks enc_a/enc_b through Gray-code steps until the
// internal position reaches an accepted target, with optional contact-bounce glitches.
module quad_encoder_gen #(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 16,
  parameter int BOUNCE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic             enc_a,
  output logic             enc_b,
  output logic [WIDTH-1:0] position,
  output logic             busy
);

  localparam int CNT_W = $clog2(STEP_CYCLES + 2 * BOUNCE + 2) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE > 0) ? 2 * BOUNCE - 1 : 0);
  localparam logic [WIDTH-1:0] HALF        = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_BOUNCE,
    ST_HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg, tgt_next;
  logic [WIDTH-1:0] pos_reg, pos_next;
  logic [1:0]       gray_reg, gray_next;   // {a, b} after the latest commit
  logic [1:0]       mask_reg, mask_next;   // line that changed at the latest commit
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       enc_reg, enc_next;
  logic [WIDTH-1:0] diff;

  assign diff = tgt_reg - pos_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      tgt_reg   <= '0;
      pos_reg   <= '0;
      gray_reg  <= '0;
      mask_reg  <= '0;
      cnt_reg   <= '0;
      enc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      pos_reg   <= pos_next;
      gray_reg  <= gray_next;
      mask_reg  <= mask_next;
      cnt_reg   <= cnt_next;
      enc_reg   <= enc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    pos_next   = pos_reg;
    gray_next  = gray_reg;
    mask_next  = mask_reg;
    cnt_next   = cnt_reg;
    enc_next   = gray_reg;

    case (state_reg)
      ST_IDLE: begin
        if (target_valid) begin
          tgt_next   = target;
          state_next = ST_DECIDE;
        end
      end

      ST_DECIDE: begin
        if (diff == '0) begin
          state_next = ST_IDLE;
        end else begin
          // Exactly half way round goes up, so the tie case is deterministic.
          if (diff <= HALF) begin
            gray_next = {~gray_reg[0], gray_reg[1]};
            pos_next  = pos_reg + 1'b1;
          end else begin
            gray_next = {gray_reg[0], ~gray_reg[1]};
            pos_next  = pos_reg - 1'b1;
          end
          mask_next  = gray_reg ^ gray_next;
          cnt_next   = '0;
          state_next = (BOUNCE > 0) ? ST_BOUNCE : ST_HOLD;
        end
      end

      ST_BOUNCE: begin
        // Odd slots flip the changed line back to its old level.
        if (cnt_reg[0]) begin
          enc_next = gray_reg ^ mask_reg;
        end
        if (cnt_reg == BOUNCE_LAST) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = ST_DECIDE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign enc_a        = enc_reg[1];
  assign enc_b        = enc_reg[0];
  assign position     = pos_reg;
  assign target_ready = (state_reg == ST_IDLE);
  assign busy         = ~target_ready;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: two instances (clean and bouncing) checked per cycle
// against an arithmetic timeline of each walk.
module tb_quad_encoder_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] target;
  logic       target_valid;

  logic       enc_a0, enc_b0, enc_a1, enc_b1;
  logic [7:0] pos_obs   [2];
  logic       busy_obs  [2];
  logic       ready_obs [2];

  int checks_total  = 0;
  int checks_passed = 0;
  int model_pos;
  int model_phase;
  int walk_no = 0;

  // Per-step period = 1 + 2*BOUNCE + STEP_CYCLES for each instance.
  int per_tab [2] = '{5, 8};
  int nb_tab  [2] = '{0, 2};
  // Quadrature phase index -> {a,b}; up sequence 00,10,11,01.
  int gray_tab [4] = '{0, 2, 3, 1};

  always #5 clk = ~clk;

  quad_encoder_gen #(.WIDTH(8), .STEP_CYCLES(4), .BOUNCE(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (ready_obs[0]),
    .enc_a        (enc_a0),
    .enc_b        (enc_b0),
    .position     (pos_obs[0]),
    .busy         (busy_obs[0])
  );

  quad_encoder_gen #(.WIDTH(8), .STEP_CYCLES(3), .BOUNCE(2)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (ready_obs[1]),
    .enc_a        (enc_a1),
    .enc_b        (enc_b1),
    .position     (pos_obs[1]),
    .busy         (busy_obs[1])
  );

  function automatic int enc_obs(input int d);
    if (d == 0) return {30'd0, enc_a0, enc_b0};
    return {30'd0, enc_a1, enc_b1};
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected outputs i edges after the acceptance edge of a walk of n steps.
  task automatic expect_at(input int p0, input int g0, input int n, input int dir,
                           input int per, input int nb, input int i,
                           output int e_enc, output int e_pos, output int e_busy);
    int c, m, s, j, ph;
    c = 0;
    if (i >= 1) begin
      c = (i - 1) / per + 1;
      if (c > n) c = n;
    end
    e_pos  = (p0 + dir * c) & 255;
    e_busy = (i <= n * per) ? 1 : 0;
    m = i - 2;
    if (m < 0) begin
      ph = g0;
    end else begin
      s = m / per;
      j = m % per;
      if (s >= n) ph = g0 + dir * n;
      else if (j < 2 * nb && (j % 2) == 1) ph = g0 + dir * s;
      else ph = g0 + dir * (s + 1);
    end
    e_enc = gray_tab[ph & 3];
  endtask

  task automatic check_idle_reset(input string what);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s d%0d enc", what, d), enc_obs(d), 0);
      check_eq($sformatf("%s d%0d pos", what, d), int'(pos_obs[d]), 0);
      check_eq($sformatf("%s d%0d busy", what, d), int'(busy_obs[d]), 0);
      check_eq($sformatf("%s d%0d ready", what, d), int'(ready_obs[d]), 1);
    end
  endtask

  task automatic run_walk(input int t, input bit hold_junk, input int reset_at);
    int p0, g0, diff, n, dir, imax;
    int e_enc, e_pos, e_busy;
    bit done;
    p0   = model_pos;
    g0   = model_phase;
    diff = (t - p0) & 255;
    if (diff == 0) begin n = 0; dir = 1; end
    else if (diff <= 128) begin n = diff; dir = 1; end
    else begin n = 256 - diff; dir = -1; end
    walk_no++;
    $display("walk %0d: pos %0d -> target %0d, %0d steps %s%s", walk_no, p0, t, n,
             (dir > 0) ? "up" : "down", (reset_at >= 0) ? ", reset mid-walk" : "");
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("w%0d d%0d ready_before", walk_no, d), int'(ready_obs[d]), 1);
    target       = t[7:0];
    target_valid = 1'b1;
    @(posedge clk); #1;
    imax = n * 8 + 2;
    done = 1'b0;
    for (int i = 0; i <= imax && !done; i++) begin
      for (int d = 0; d < 2; d++) begin
        expect_at(p0, g0, n, dir, per_tab[d], nb_tab[d], i, e_enc, e_pos, e_busy);
        check_eq($sformatf("w%0d d%0d i%0d enc", walk_no, d, i), enc_obs(d), e_enc);
        check_eq($sformatf("w%0d d%0d i%0d pos", walk_no, d, i), int'(pos_obs[d]), e_pos);
        check_eq($sformatf("w%0d d%0d i%0d busy", walk_no, d, i), int'(busy_obs[d]), e_busy);
        check_eq($sformatf("w%0d d%0d i%0d ready", walk_no, d, i), int'(ready_obs[d]), 1 - e_busy);
      end
      if (i == reset_at) begin
        target_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk); #1;
        check_idle_reset($sformatf("w%0d reset", walk_no));
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle_reset($sformatf("w%0d after_reset", walk_no));
        model_pos   = 0;
        model_phase = 0;
        done        = 1'b1;
      end else begin
        // Offer a different target during the walk; it must be ignored.
        if (hold_junk && i < n * 5) begin
          target_valid = 1'b1;
          target       = 8'($urandom);
        end else begin
          target_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      model_pos   = t & 255;
      model_phase = (g0 + dir * n) & 3;
    end
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    target_valid = 1'b0;
    target       = 8'd0;
    model_pos    = 0;
    model_phase  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_walk(3, 1'b0, -1);
    run_walk(3, 1'b0, -1);
    run_walk(0, 1'b0, -1);
    run_walk(8'hFE, 1'b0, -1);
    run_walk(0, 1'b1, -1);
    run_walk(8'h80, 1'b0, -1);
    run_walk(4, 1'b1, -1);
    run_walk(20, 1'b0, 2);
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) t = model_pos;
      else t = int'($urandom_range(0, 255));
      run_walk(t, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
